muldiv_seq: RTL

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_pkg.sv | 27 ++
 rtl/muldiv_seq.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants for the sequential RV32M multiply/divide unit:
// funct3 op codes, FSM state encoding and the iteration count.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_PREP = 3'd1;
  localparam state_t S_CALC = 3'd2;
  localparam state_t S_FIX  = 3'd3;
  localparam state_t S_DONE = 3'd4;

  localparam int CALC_CYCLES = 32;

  function automatic logic is_mul(input logic [2:0] op);
    return ~op[2];
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Sequential RV32M multiply/divide: shift-add multiply, restoring divide, 35-cycle path.
// Optional macro MULDIV_EARLY_OUT_EN short-cuts trivial operations straight from PREP to DONE.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_100M,
  input  logic            rst_n,
  input  logic            req,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            alu_complete,
  output logic            done
);

  localparam logic [4:0] LAST_CYCLE = 5'(CALC_CYCLES - 1);

  state_t          state;
  logic            req_q;
  logic [2:0]      op_q;
  logic [XLEN-1:0] a_q, b_q;
  logic [XLEN-1:0] opnd_q;   // multiplicand or divisor magnitude
  logic [XLEN:0]   acc_hi;   // product high half / partial remainder
  logic [XLEN-1:0] acc_lo;   // multiplier / dividend, becomes product low half / quotient
  logic            neg_q;
  logic [4:0]      cnt;

  logic            launch;
  logic            sa, sb, neg;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN:0]   mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0] rem_raw, quo_fix, rem_fix, fix_val;

  assign launch = (state == S_IDLE) && req && !req_q;

  // Operand signedness and final result sign depend only on the op.
  always_comb begin
    sa  = 1'b0;
    sb  = 1'b0;
    neg = 1'b0;
    case (op_q)
      OP_MULH:   begin sa = a_q[XLEN-1]; sb = b_q[XLEN-1]; neg = sa ^ sb; end
      OP_MULHSU: begin sa = a_q[XLEN-1]; neg = sa; end
      OP_DIV:    begin sa = a_q[XLEN-1]; sb = b_q[XLEN-1]; neg = (sa ^ sb) && (|b_q); end
      OP_REM:    begin sa = a_q[XLEN-1]; sb = b_q[XLEN-1]; neg = sa; end
      default:   ;
    endcase
    mag_a = sa ? -a_q : a_q;
    mag_b = sb ? -b_q : b_q;
  end

  always_comb begin
    mul_sum   = {1'b0, acc_hi[XLEN-1:0]} + (acc_lo[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_hi[XLEN-1:0], acc_lo[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
  end

  always_comb begin
    prod     = {acc_hi[XLEN-1:0], acc_lo};
    prod_fix = neg_q ? -prod : prod;
    rem_raw  = acc_hi[XLEN-1:0];
    quo_fix  = neg_q ? -acc_lo : acc_lo;
    rem_fix  = neg_q ? -rem_raw : rem_raw;
    case (op_q)
      OP_MUL:                      fix_val = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_val = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             fix_val = quo_fix;
      default:                     fix_val = rem_fix;
    endcase
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic            early;
  logic [XLEN-1:0] early_val;

  always_comb begin
    early     = 1'b0;
    early_val = '0;
    if (is_mul(op_q)) begin
      early = (a_q == '0) || (b_q == '0);
    end else if (b_q == '0) begin
      early     = 1'b1;
      early_val = op_q[1] ? a_q : '1;
    end else if (!op_q[0] && a_q == {1'b1, {(XLEN-1){1'b0}}} && b_q == '1) begin
      early     = 1'b1;
      early_val = op_q[1] ? '0 : a_q;
    end
  end
`endif

  // NOTE: all state here updates with non-blocking assignments so every register
  // samples the pre-edge values; the datapath registers are reset too so an
  // aborted operation leaves nothing stale behind.
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      req_q        <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      opnd_q       <= '0;
      acc_hi       <= '0;
      acc_lo       <= '0;
      neg_q        <= 1'b0;
      cnt          <= '0;
      result       <= '0;
      alu_complete <= 1'b1;
      done         <= 1'b0;
    end else begin
      req_q <= req;
      done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (launch) begin
            op_q         <= op;
            a_q          <= a;
            b_q          <= b;
            alu_complete <= 1'b0;
            state        <= S_PREP;
          end
        end
        S_PREP: begin
          neg_q  <= neg;
          cnt    <= '0;
          acc_hi <= '0;
          acc_lo <= is_mul(op_q) ? mag_b : mag_a;
          opnd_q <= is_mul(op_q) ? mag_a : mag_b;
          state  <= S_CALC;
`ifdef MULDIV_EARLY_OUT_EN
          if (early) begin
            result       <= early_val;
            done         <= 1'b1;
            alu_complete <= 1'b1;
            state        <= S_DONE;
          end
`endif
        end
        S_CALC: begin
          cnt <= cnt + 5'd1;
          if (is_mul(op_q)) begin
            acc_hi <= {1'b0, mul_sum[XLEN:1]};
            acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
          end else if (!div_diff[XLEN]) begin
            acc_hi <= div_diff;
            acc_lo <= {acc_lo[XLEN-2:0], 1'b1};
          end else begin
            acc_hi <= div_shift;
            acc_lo <= {acc_lo[XLEN-2:0], 1'b0};
          end
          if (cnt == LAST_CYCLE) state <= S_FIX;
        end
        S_FIX: begin
          result       <= fix_val;
          done         <= 1'b1;
          alu_complete <= 1'b1;
          state        <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
